snes_poller: RTL and testbench

Sequencer that reads a serial SNES-style game pad once per poll period. A `flex_counter` poll timer (default 833333 cycles, 60 Hz at 50 MHz) triggers each read. The block then drives the pad's latch and clock pins, shifts in the button bits, and publishes a registered, active-high button word with a one-cycle `valid` strobe. It sits between the board GPIO pins and the controller-mapping logic.

---
 rtl/controller_pkg.sv | 23 ++
 rtl/flex_counter.sv | 51 +++++
 rtl/snes_poller.sv | 140 ++++++++++++++
 tb/tb_snes_poller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// ============================================================================
// controller_pkg : shared state encoding and 50 MHz default timing for the
//                  SNES pad poller.   Rev 1.0
// ============================================================================
`default_nettype none

package controller_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LATCH    = 3'd1,
        CLK_HIGH = 3'd2,
        CLK_LOW  = 3'd3,
        DONE     = 3'd4
    } poll_state_t;

    localparam int POLL_PERIOD_60HZ = 833333;
    localparam int LATCH_12US       = 600;
    localparam int HALF_BIT_6US     = 300;

endpackage

`default_nettype wire

// File: rtl/flex_counter.sv
// ============================================================================
// flex_counter : programmable up-counter, counts 1..rollover_val and flags the
//                cycle in which the count equals rollover_val.   Rev 1.0
// ============================================================================
`default_nettype none

module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] r_count;
    logic [NUM_CNT_BITS-1:0] w_next_count;
    logic                    r_flag;
    logic                    w_next_flag;

    always_comb begin
        w_next_count = r_count;
        w_next_flag  = r_flag;
        if (clear) begin
            w_next_count = '0;
            w_next_flag  = 1'b0;
        end else if (count_enable) begin
            w_next_count = (r_count == rollover_val) ? NUM_CNT_BITS'(1) : r_count + 1'b1;
            w_next_flag  = (w_next_count == rollover_val);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
            r_flag  <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_flag  <= w_next_flag;
        end
    end

    assign count_out     = r_count;
    assign rollover_flag = r_flag;

endmodule

`default_nettype wire

// File: rtl/snes_poller.sv
// ============================================================================
// snes_poller : periodic serial game-pad reader; drives latch/pclk, shifts in
//               NUM_BUTTONS active-low bits and publishes them active-high.   Rev 1.0
// ============================================================================
`default_nettype none

module snes_poller
    import controller_pkg::*;
#(
    parameter int POLL_PERIOD  = POLL_PERIOD_60HZ,
    parameter int LATCH_CYCLES = LATCH_12US,
    parameter int HALF_BIT     = HALF_BIT_6US,
    parameter int NUM_BUTTONS  = 16
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   enable,
    input  logic                   ser_data,
    output logic                   latch,
    output logic                   pclk,
    output logic [NUM_BUTTONS-1:0] buttons,
    output logic                   valid,
    output logic                   overrun
);

    localparam int CNT_W   = $clog2(POLL_PERIOD + 1);
    localparam int TMR_MAX = (LATCH_CYCLES > HALF_BIT) ? LATCH_CYCLES : HALF_BIT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int IDX_W   = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;

    localparam logic [TMR_W-1:0] LATCH_LOAD = TMR_W'(LATCH_CYCLES - 1);
    localparam logic [TMR_W-1:0] HALF_LOAD  = TMR_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BUTTONS - 1);

    logic                   w_tick;
    logic [CNT_W-1:0]       w_unused_poll_count;

    poll_state_t            r_state;
    logic [TMR_W-1:0]       r_timer;
    logic [IDX_W-1:0]       r_idx;
    logic [1:0]             r_sync;
    logic [NUM_BUTTONS-1:0] r_shift;
    logic [NUM_BUTTONS-1:0] r_buttons;
    logic                   r_latch;
    logic                   r_pclk;
    logic                   r_valid;
    logic                   r_overrun;

    flex_counter #(
        .NUM_CNT_BITS (CNT_W)
    ) u_poll_timer (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (!enable),
        .count_enable  (enable),
        .rollover_val  (CNT_W'(POLL_PERIOD)),
        .count_out     (w_unused_poll_count),
        .rollover_flag (w_tick)
    );

    // Phase timer counts down from N-1 so each phase lasts exactly N cycles.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_idx     <= '0;
            r_sync    <= 2'b11;
            r_shift   <= '0;
            r_buttons <= '0;
            r_latch   <= 1'b0;
            r_pclk    <= 1'b1;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], ser_data};
            r_valid   <= 1'b0;
            r_overrun <= w_tick && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_tick) begin
                        r_state <= LATCH;
                        r_latch <= 1'b1;
                        r_timer <= LATCH_LOAD;
                    end
                end
                LATCH: begin
                    if (r_timer == '0) begin
                        r_state <= CLK_HIGH;
                        r_latch <= 1'b0;
                        r_timer <= HALF_LOAD;
                        r_idx   <= '0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                CLK_HIGH: begin
                    if (r_timer == '0) begin
                        r_shift[r_idx] <= ~r_sync[1];
                        r_state        <= CLK_LOW;
                        r_pclk         <= 1'b0;
                        r_timer        <= HALF_LOAD;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                CLK_LOW: begin
                    if (r_timer == '0) begin
                        r_pclk  <= 1'b1;
                        r_timer <= HALF_LOAD;
                        if (r_idx == LAST_IDX) begin
                            r_state   <= DONE;
                            r_buttons <= r_shift;
                            r_valid   <= 1'b1;
                        end else begin
                            r_state <= CLK_HIGH;
                            r_idx   <= r_idx + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign latch   = r_latch;
    assign pclk    = r_pclk;
    assign buttons = r_buttons;
    assign valid   = r_valid;
    assign overrun = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_snes_poller.sv
// ============================================================================
// tb_snes_poller : scoreboard bench with a pad model for snes_poller.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_snes_poller;

    logic        clk;
    logic        n_rst;
    logic        enable;
    logic        ser_data;
    logic        latch;
    logic        pclk;
    logic [15:0] buttons;
    logic        valid;
    logic        overrun;

    logic        n_rst2;
    logic        enable2;
    logic        ser_data2;
    logic        latch2;
    logic        pclk2;
    logic [15:0] buttons2;
    logic        valid2;
    logic        overrun2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cyc2     = 0;

    logic [15:0] pad_word;
    logic [15:0] exp_q[$];
    logic [15:0] last_exp;

    int latch_rises = 0, pclk_falls = 0, pclk_low_cycles = 0, ov_count = 0;
    int latch2_rises = 0, ov2_count = 0, ov2_first = -1;
    logic prev_latch = 1'b0, prev_pclk = 1'b1, prev_latch2 = 1'b0;

    snes_poller #(
        .POLL_PERIOD (200),
        .LATCH_CYCLES(4),
        .HALF_BIT    (4),
        .NUM_BUTTONS (16)
    ) u_dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .enable   (enable),
        .ser_data (ser_data),
        .latch    (latch),
        .pclk     (pclk),
        .buttons  (buttons),
        .valid    (valid),
        .overrun  (overrun)
    );

    snes_poller #(
        .POLL_PERIOD (100),
        .LATCH_CYCLES(4),
        .HALF_BIT    (4),
        .NUM_BUTTONS (16)
    ) u_dut_ov (
        .clk      (clk),
        .n_rst    (n_rst2),
        .enable   (enable2),
        .ser_data (ser_data2),
        .latch    (latch2),
        .pclk     (pclk2),
        .buttons  (buttons2),
        .valid    (valid2),
        .overrun  (overrun2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge n_rst)
        if (!n_rst) cyc <= 0;
        else        cyc <= cyc + 1;

    always @(posedge clk or negedge n_rst2)
        if (!n_rst2) cyc2 <= 0;
        else         cyc2 <= cyc2 + 1;

    function automatic void check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     nm, act, act, exp, exp, $time);
        end
    endfunction

    // Pad model: snapshots pad_word when latch falls, then presents the next
    // active-low bit after every pclk rise.
    initial begin : pad_model
        logic [15:0] snap;
        int          idx;
        logic        pl, pp;
        snap = '0; idx = 0; pl = 1'b0; pp = 1'b1;
        ser_data = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (pl && !latch) begin
                snap     = pad_word;
                idx      = 0;
                ser_data = ~snap[0];
            end else if (!pp && pclk && !latch) begin
                idx++;
                ser_data = (idx < 16) ? ~snap[idx] : 1'b0;
            end
            pl = latch;
            pp = pclk;
        end
    end

    always @(negedge clk) begin
        if (latch && !prev_latch) latch_rises++;
        if (!pclk && prev_pclk)   pclk_falls++;
        if (!pclk)                pclk_low_cycles++;
        if (overrun)              ov_count++;
        if (latch2 && !prev_latch2) latch2_rises++;
        if (overrun2) begin
            ov2_count++;
            if (ov2_first < 0) ov2_first = cyc2;
        end
        prev_latch  = latch;
        prev_pclk   = pclk;
        prev_latch2 = latch2;
    end

    // Scoreboard monitor: pops on every valid, otherwise checks the held word.
    always @(negedge clk) begin
        if (!n_rst) begin
            last_exp = '0;
        end else if (valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                last_exp = exp_q.pop_front();
                check("buttons_on_valid", int'(buttons), int'(last_exp));
            end
        end else begin
            check("buttons_hold", int'(buttons), int'(last_exp));
        end
    end

    task automatic wait_for(input int which, input int bound, output int t);
        int   n;
        logic hit;
        t = -1;
        n = 0;
        while (n < bound && t < 0) begin
            @(negedge clk);
            n++;
            case (which)
                0:       hit = latch;
                1:       hit = valid;
                2:       hit = latch2;
                default: hit = valid2;
            endcase
            if (hit) t = (which >= 2) ? cyc2 : cyc;
        end
        if (t < 0) check("wait_timeout", which, -1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int t_l, t_v, f0, l0, r0;
        n_rst     = 1'b0;
        n_rst2    = 1'b0;
        enable    = 1'b1;
        enable2   = 1'b1;
        ser_data2 = 1'b1;
        pad_word  = 16'h0000;

        repeat (3) @(negedge clk);
        check("rst_latch",   int'(latch),   0);
        check("rst_pclk",    int'(pclk),    1);
        check("rst_buttons", int'(buttons), 0);
        check("rst_valid",   int'(valid),   0);
        check("rst_overrun", int'(overrun), 0);
        n_rst = 1'b1;

        // No buttons pressed: first latch at cycle 201, zero word published.
        exp_q.push_back(16'h0000);
        wait_for(0, 400, t_l);
        check("first_latch_cycle", t_l, 201);
        wait_for(1, 400, t_v);
        check("valid_latency_idle", t_v - t_l, 132);
        @(negedge clk);
        check("valid_one_cycle", int'(valid), 0);

        // Pad presents 16'h5A3C.
        pad_word = 16'h5A3C;
        exp_q.push_back(16'h5A3C);
        f0 = pclk_falls;
        l0 = pclk_low_cycles;
        wait_for(0, 400, t_l);
        check("poll_spacing", t_l, 401);
        wait_for(1, 400, t_v);
        check("valid_latency_5a3c", t_v - t_l, 132);
        check("pclk_low_pulses", pclk_falls - f0, 16);
        check("pclk_low_cycles", pclk_low_cycles - l0, 64);
        check("no_overrun", ov_count, 0);

        // Pad switches to all-pressed during the next read's latch.
        wait_for(0, 400, t_l);
        pad_word = 16'hFFFF;
        exp_q.push_back(16'hFFFF);
        wait_for(1, 400, t_v);
        check("valid_latency_ffff", t_v - t_l, 132);

        // Enable dropped at tick+20: read still completes, then silence.
        exp_q.push_back(16'hFFFF);
        wait_for(0, 400, t_l);
        repeat (19) @(negedge clk);
        enable = 1'b0;
        wait_for(1, 400, t_v);
        check("valid_latency_en_drop", t_v - t_l, 132);
        r0 = latch_rises;
        repeat (1000) @(negedge clk);
        check("no_latch_when_disabled", latch_rises - r0, 0);
        check("no_overrun_total", ov_count, 0);
        enable = 1'b1;

        // Reset asserted at tick+50: partial read discarded.
        pad_word = 16'h0F0F;
        wait_for(0, 400, t_l);
        repeat (49) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("midread_rst_latch",   int'(latch),   0);
        check("midread_rst_pclk",    int'(pclk),    1);
        check("midread_rst_buttons", int'(buttons), 0);
        check("midread_rst_valid",   int'(valid),   0);
        @(negedge clk);
        n_rst = 1'b1;
        exp_q.push_back(16'h0F0F);
        wait_for(0, 400, t_l);
        check("latch_after_rst", t_l, 201);
        wait_for(1, 400, t_v);
        check("valid_latency_0f0f", t_v - t_l, 132);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        // Short poll period: tick lands mid-read.
        @(negedge clk);
        n_rst2 = 1'b1;
        wait_for(2, 300, t_l);
        check("ov_first_latch", t_l, 101);
        wait_for(3, 300, t_v);
        check("ov_valid_cycle", t_v, 233);
        check("ov_buttons", int'(buttons2), 0);
        check("ov_pulse_count", ov2_count, 1);
        check("ov_pulse_cycle", ov2_first, 201);
        check("ov_single_latch", latch2_rises, 1);
        wait_for(2, 200, t_l);
        check("ov_next_latch", t_l, 301);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
